// File: rtl/seq_pkg.sv
// Shared types and defaults for the multi-cycle datapath sequencer.
package seq_pkg;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'h3F;
    localparam int         ADDR_W_DEF      = 5;
    localparam int         COUNT_W_DEF     = 32;

    // One state per pipeline-less stage, plus the two parked states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } seq_state_e;

    // Parked states are the only ones where the host may use the write port.
    function automatic logic is_parked(input seq_state_e s);
        return (s == ST_IDLE) || (s == ST_HALT);
    endfunction

endpackage

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the datapath owns the port in WRITEBACK,
// the host debug port owns it while the sequencer is parked.
module wb_port_arbiter
    import seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              enable,
    input  seq_state_e        state,
    input  logic              dp_reg_write,
    input  logic [ADDR_W-1:0] dp_wr_addr,
    input  logic              dbg_wr_req,
    input  logic [ADDR_W-1:0] dbg_wr_addr,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic              wr_sel,
    output logic              dbg_wr_ack
);

    // Same-cycle grant; enable drops the port to idle while reset is held.
    always_comb begin
        rf_write   = 1'b0;
        rf_wr_addr = {ADDR_W{1'b0}};
        wr_sel     = 1'b0;
        dbg_wr_ack = 1'b0;
        if (enable && is_parked(state) && dbg_wr_req) begin
            rf_write   = 1'b1;
            rf_wr_addr = dbg_wr_addr;
            wr_sel     = 1'b1;
            dbg_wr_ack = 1'b1;
        end else if (enable && (state == ST_WRITEBACK)) begin
            rf_write   = dp_reg_write;
            rf_wr_addr = dp_wr_addr;
        end else begin
            rf_write   = 1'b0;
            rf_wr_addr = {ADDR_W{1'b0}};
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller stepping the datapath through FETCH, DECODE,
// EXECUTE and WRITEBACK, with a retired-instruction counter and a host
// debug write path that is only serviced between instructions.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int         ADDR_W      = ADDR_W_DEF,
    parameter int         COUNT_W     = COUNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               step_mode,
    input  logic [5:0]         opcode,
    input  logic               dp_reg_write,
    input  logic [ADDR_W-1:0]  dp_wr_addr,
    input  logic               dbg_wr_req,
    input  logic [ADDR_W-1:0]  dbg_wr_addr,
    output logic               ir_load,
    output logic               pc_en,
    output logic               rf_write,
    output logic [ADDR_W-1:0]  rf_wr_addr,
    output logic               wr_sel,
    output logic               dbg_wr_ack,
    output logic               busy,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               ir_load_q;
    logic               busy_q;
    logic               halted_q;
    logic               halt_hit;

    assign halt_hit = (opcode == HALT_OPCODE);

    // Next-state selection; a pending debug write holds the sequencer parked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (dbg_wr_req) begin
                    state_d = state_q;
                end else if (start) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH:   state_d = ST_DECODE;
            ST_DECODE: begin
                if (halt_hit) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: state_d = ST_WRITEBACK;
            ST_WRITEBACK: begin
                if (stop || step_mode) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Retired-instruction counter advances in WRITEBACK and sticks at all-ones.
    always_comb begin
        if ((state_q == ST_WRITEBACK) && (count_q != COUNT_MAX)) begin
            count_d = count_q + COUNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // State register with stage-decoded outputs registered from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= {COUNT_W{1'b0}};
            ir_load_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ir_load_q <= (state_d == ST_FETCH);
            busy_q    <= (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
                         (state_d == ST_EXECUTE) || (state_d == ST_WRITEBACK);
            halted_q  <= (state_d == ST_HALT);
        end
    end

    // PC advances on retirement, or in DECODE so a resumed run skips the halt.
    always_comb begin
        if (state_q == ST_WRITEBACK) begin
            pc_en = 1'b1;
        end else if ((state_q == ST_DECODE) && halt_hit) begin
            pc_en = 1'b1;
        end else begin
            pc_en = 1'b0;
        end
    end

    assign ir_load     = ir_load_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

    wb_port_arbiter #(
        .ADDR_W (ADDR_W)
    ) u_arb (
        .enable       (reset),
        .state        (state_q),
        .dp_reg_write (dp_reg_write),
        .dp_wr_addr   (dp_wr_addr),
        .dbg_wr_req   (dbg_wr_req),
        .dbg_wr_addr  (dbg_wr_addr),
        .rf_write     (rf_write),
        .rf_wr_addr   (rf_wr_addr),
        .wr_sel       (wr_sel),
        .dbg_wr_ack   (dbg_wr_ack)
    );

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: a behavioural model tracks how far
// the current instruction has progressed and how many have retired, and a
// negedge compare process checks every output against it each cycle.
module tb_datapath_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, stop, step_mode;
    logic [5:0] opcode;
    logic       dp_reg_write;
    logic [4:0] dp_wr_addr;
    logic       dbg_wr_req;
    logic [4:0] dbg_wr_addr;

    logic        ir_load, pc_en, rf_write, wr_sel, dbg_wr_ack, busy, halted;
    logic [4:0]  rf_wr_addr;
    logic [31:0] instr_count;

    logic        s_ir_load, s_pc_en, s_rf_write, s_wr_sel, s_dbg_wr_ack, s_busy, s_halted;
    logic [4:0]  s_rf_wr_addr;
    logic [1:0]  s_instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    datapath_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .step_mode(step_mode), .opcode(opcode), .dp_reg_write(dp_reg_write),
        .dp_wr_addr(dp_wr_addr), .dbg_wr_req(dbg_wr_req), .dbg_wr_addr(dbg_wr_addr),
        .ir_load(ir_load), .pc_en(pc_en), .rf_write(rf_write), .rf_wr_addr(rf_wr_addr),
        .wr_sel(wr_sel), .dbg_wr_ack(dbg_wr_ack), .busy(busy), .halted(halted),
        .instr_count(instr_count)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    datapath_sequencer #(.COUNT_W(2)) dut_small (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .step_mode(step_mode), .opcode(opcode), .dp_reg_write(dp_reg_write),
        .dp_wr_addr(dp_wr_addr), .dbg_wr_req(dbg_wr_req), .dbg_wr_addr(dbg_wr_addr),
        .ir_load(s_ir_load), .pc_en(s_pc_en), .rf_write(s_rf_write), .rf_wr_addr(s_rf_wr_addr),
        .wr_sel(s_wr_sel), .dbg_wr_ack(s_dbg_wr_ack), .busy(s_busy), .halted(s_halted),
        .instr_count(s_instr_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Model: m_pos = cycles into the current instruction (0 = parked),
    // m_halt = parked because of a halt opcode, m_retired = retirements.
    int     m_pos;
    bit     m_halt;
    longint m_retired;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pos <= 0; m_halt <= 1'b0; m_retired <= 0;
        end else if (m_pos == 0) begin
            if (!dbg_wr_req && start) begin
                m_pos <= 1; m_halt <= 1'b0;
            end
        end else if (m_pos == 2 && opcode == 6'h3F) begin
            m_pos <= 0; m_halt <= 1'b1;
        end else if (m_pos == 4) begin
            m_retired <= m_retired + 1;
            m_pos <= (stop || step_mode) ? 0 : 1;
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        logic        g, e_wr, e_pc;
        logic [4:0]  e_addr;
        logic [31:0] e_cnt, e_scnt;
        g      = reset && (m_pos == 0) && dbg_wr_req;
        e_wr   = g ? 1'b1 : (reset && m_pos == 4) ? dp_reg_write : 1'b0;
        e_addr = g ? dbg_wr_addr : (reset && m_pos == 4) ? dp_wr_addr : 5'd0;
        e_pc   = reset && ((m_pos == 4) || (m_pos == 2 && opcode == 6'h3F));
        e_cnt  = m_retired[31:0];
        e_scnt = (m_retired > 3) ? 32'd3 : m_retired[31:0];
        chk("ir_load",    {31'd0, ir_load},    {31'd0, reset && m_pos == 1});
        chk("pc_en",      {31'd0, pc_en},      {31'd0, e_pc});
        chk("rf_write",   {31'd0, rf_write},   {31'd0, e_wr});
        chk("rf_wr_addr", {27'd0, rf_wr_addr}, {27'd0, e_addr});
        chk("wr_sel",     {31'd0, wr_sel},     {31'd0, g});
        chk("dbg_wr_ack", {31'd0, dbg_wr_ack}, {31'd0, g});
        chk("busy",       {31'd0, busy},       {31'd0, reset && m_pos != 0});
        chk("halted",     {31'd0, halted},     {31'd0, reset && m_pos == 0 && m_halt});
        chk("instr_count", instr_count, e_cnt);
        chk("small_count", {30'd0, s_instr_count}, e_scnt);
        chk("small_rf_write", {31'd0, s_rf_write}, {31'd0, e_wr});
    end

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; step_mode = 1'b0;
        opcode = 6'd0; dp_reg_write = 1'b0; dp_wr_addr = 5'd0;
        dbg_wr_req = 1'b0; dbg_wr_addr = 5'd0;
        repeat (3) step();
        @(negedge clock);
        chk("lit_reset_busy", {31'd0, busy}, 32'd0);
        chk("lit_reset_count", instr_count, 32'd0);
        step(); reset = 1'b1;

        // R-type with write to r5, then continuous run.
        opcode = 6'd0; dp_reg_write = 1'b1; dp_wr_addr = 5'd5; start = 1'b1;
        step(); start = 1'b0;                       // FETCH
        @(negedge clock);
        chk("lit_fetch_ir_load", {31'd0, ir_load}, 32'd1);
        step();                                     // DECODE
        step();                                     // EXECUTE
        step();                                     // WRITEBACK
        @(negedge clock);
        chk("lit_wb_rf_write", {31'd0, rf_write}, 32'd1);
        chk("lit_wb_addr", {27'd0, rf_wr_addr}, 32'd5);
        chk("lit_wb_pc_en", {31'd0, pc_en}, 32'd1);
        step();                                     // FETCH #2
        @(negedge clock);
        chk("lit_count_after_1", instr_count, 32'd1);
        step(); dp_reg_write = 1'b0; dp_wr_addr = 5'd12;   // DECODE #2
        step(); stop = 1'b1;                        // EXECUTE #2, stop ignored here
        step(); stop = 1'b0;                        // WRITEBACK #2
        step(); dp_reg_write = 1'b1; dp_wr_addr = 5'd31;   // FETCH #3
        repeat (3) step();                          // WRITEBACK #3
        step(); opcode = 6'h3F;                     // FETCH of halt
        @(negedge clock);
        chk("lit_count_3", instr_count, 32'd3);
        step();                                     // DECODE halt
        @(negedge clock);
        chk("lit_halt_pc_en", {31'd0, pc_en}, 32'd1);
        chk("lit_halt_no_write", {31'd0, rf_write}, 32'd0);

        // HALT: debug write with start in the same cycle.
        step(); opcode = 6'd0; dbg_wr_req = 1'b1; dbg_wr_addr = 5'd7; start = 1'b1;
        @(negedge clock);
        chk("lit_halted", {31'd0, halted}, 32'd1);
        chk("lit_halt_ack", {31'd0, dbg_wr_ack}, 32'd1);
        chk("lit_halt_dbg_addr", {27'd0, rf_wr_addr}, 32'd7);
        step(); dbg_wr_req = 1'b0;                  // still HALT
        step(); start = 1'b0;                       // FETCH #4 (resume)
        dbg_wr_req = 1'b1; dbg_wr_addr = 5'd9;      // pending while running
        @(negedge clock);
        chk("lit_resume_ir_load", {31'd0, ir_load}, 32'd1);
        chk("lit_running_no_ack", {31'd0, dbg_wr_ack}, 32'd0);
        repeat (8) step();                          // FETCH #6
        stop = 1'b1;
        repeat (4) step(); stop = 1'b0; start = 1'b1;   // IDLE
        @(negedge clock);
        chk("lit_idle_ack", {31'd0, dbg_wr_ack}, 32'd1);
        chk("lit_idle_sel", {31'd0, wr_sel}, 32'd1);
        chk("lit_idle_addr", {27'd0, rf_wr_addr}, 32'd9);
        chk("lit_count_6", instr_count, 32'd6);
        step(); dbg_wr_req = 1'b0;                  // IDLE, start now honoured
        step(); start = 1'b0;                       // FETCH #7
        @(negedge clock);
        chk("lit_fetch_after_dbg", {31'd0, ir_load}, 32'd1);

        // Reset in EXECUTE with a debug request and datapath write pending.
        step(); step();                             // EXECUTE #7
        reset = 1'b0; dbg_wr_req = 1'b1; dp_reg_write = 1'b1;
        @(negedge clock);
        chk("lit_rst_rf_write", {31'd0, rf_write}, 32'd0);
        chk("lit_rst_count", instr_count, 32'd0);
        step(); reset = 1'b1; dbg_wr_req = 1'b0;

        // Step mode: two single-instruction runs.
        step_mode = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        repeat (4) step();
        @(negedge clock);
        chk("lit_step1_count", instr_count, 32'd1);
        chk("lit_step1_idle", {31'd0, busy}, 32'd0);
        step(); start = 1'b1;
        step(); start = 1'b0;
        repeat (4) step();
        @(negedge clock);
        chk("lit_step2_count", instr_count, 32'd2);

        // Continuous run pushing the narrow counter past its maximum.
        step(); step_mode = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        repeat (12) step();
        stop = 1'b1;
        repeat (4) step(); stop = 1'b0;
        @(negedge clock);
        chk("lit_final_count", instr_count, 32'd6);
        chk("lit_small_saturated", {30'd0, s_instr_count}, 32'd3);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
